// File: rtl/rom_port_arbiter_pkg.sv
// Shared widths, FSM encoding and port IDs for the ROM read-port arbiter.
package rom_port_arbiter_pkg;

    localparam int unsigned API_ADDR_WIDTH = 32;
    localparam int unsigned API_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic err;
    } rsp_tag_t;

    function automatic logic addr_illegal(input logic [API_ADDR_WIDTH-1:0] addr,
                                          input int unsigned rom_bytes);
        return (addr >= rom_bytes) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Fetch, load and ROM-side signals of the arbiter; slave is the arbiter's view.
interface rom_port_arbiter_if;
    import rom_port_arbiter_pkg::*;

    logic                      if_req_i;
    logic [API_ADDR_WIDTH-1:0] if_addr_i;
    logic                      if_gnt_o;
    logic                      if_rvalid_o;
    logic [API_DATA_WIDTH-1:0] if_rdata_o;
    logic                      if_err_o;

    logic                      ls_req_i;
    logic [API_ADDR_WIDTH-1:0] ls_addr_i;
    logic                      ls_gnt_o;
    logic                      ls_rvalid_o;
    logic [API_DATA_WIDTH-1:0] ls_rdata_o;
    logic                      ls_err_o;

    logic                      rom_en_o;
    logic [API_ADDR_WIDTH-1:0] rom_addr_o;
    logic [API_DATA_WIDTH-1:0] rom_data_i;

    modport slave (
        input  if_req_i, if_addr_i, ls_req_i, ls_addr_i, rom_data_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        output rom_en_o, rom_addr_o
    );

    modport master (
        output if_req_i, if_addr_i, ls_req_i, ls_addr_i, rom_data_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
        input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
        input  rom_en_o, rom_addr_o
    );

endinterface

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer only moves when both inputs request.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       last
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (en && (req == 2'b11)) begin
            last_q <= ~last_q;
        end
    end

    assign last = last_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single ROM read port between fetch and load, with a post-reset hold-off window,
// address screening and one-cycle tagged response routing.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned ROM_BYTES   = 8192,
    parameter int unsigned INIT_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    rom_port_arbiter_if.slave bus
);

    localparam int unsigned CntW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(INIT_CYCLES - 1);

    state_e                    state_q;
    logic [CntW-1:0]           init_cnt_q;
    rsp_tag_t                  tag_q;
    logic [API_ADDR_WIDTH-1:0] rom_addr_q;
    logic [API_ADDR_WIDTH-1:0] gnt_addr;
    logic [15:0]               if_grant_cnt;
    logic [15:0]               ls_grant_cnt;
    logic [1:0]                req;
    logic [1:0]                gnt;
    logic                      run;
    logic                      last_ls;
    logic                      gnt_any;
    logic                      gnt_err;
    logic                      gnt_ok;
    logic                      if_hit;
    logic                      ls_hit;

    // Gating with reset keeps grants and responses silent while reset is held.
    assign run = (state_q == ST_RUN) && !reset;
    assign req = {bus.ls_req_i, bus.if_req_i};

    rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .reset(reset),
        .en   (run),
        .req  (req),
        .gnt  (gnt),
        .last (last_ls)
    );

    always_comb begin
        gnt_addr = gnt[PORT_LS] ? bus.ls_addr_i : bus.if_addr_i;
        gnt_any  = |gnt;
        gnt_err  = gnt_any && addr_illegal(gnt_addr, ROM_BYTES);
        gnt_ok   = gnt_any && !gnt_err;
    end

    assign bus.if_gnt_o   = gnt[PORT_IF];
    assign bus.ls_gnt_o   = gnt[PORT_LS];
    assign bus.rom_en_o   = gnt_ok;
    assign bus.rom_addr_o = gnt_ok ? gnt_addr : rom_addr_q;

    assign if_hit = tag_q.valid && (tag_q.port == PORT_IF) && !reset;
    assign ls_hit = tag_q.valid && (tag_q.port == PORT_LS) && !reset;

    assign bus.if_rvalid_o = if_hit;
    assign bus.if_err_o    = if_hit && tag_q.err;
    assign bus.if_rdata_o  = (if_hit && !tag_q.err) ? bus.rom_data_i : '0;
    assign bus.ls_rvalid_o = ls_hit;
    assign bus.ls_err_o    = ls_hit && tag_q.err;
    assign bus.ls_rdata_o  = (ls_hit && !tag_q.err) ? bus.rom_data_i : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            tag_q        <= '0;
            rom_addr_q   <= '0;
            if_grant_cnt <= '0;
            ls_grant_cnt <= '0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == CntLast) begin
                        state_q    <= ST_RUN;
                        init_cnt_q <= '0;
                    end else begin
                        init_cnt_q <= init_cnt_q + CntW'(1);
                    end
                end
                ST_RUN: state_q <= ST_RUN;
            endcase
            tag_q <= '{valid: gnt_any, port: gnt[PORT_LS], err: gnt_err};
            if (gnt_ok) begin
                rom_addr_q <= gnt_addr;
            end
            if (gnt[PORT_IF] && (if_grant_cnt != 16'hFFFF)) begin
                if_grant_cnt <= if_grant_cnt + 16'd1;
            end
            if (gnt[PORT_LS] && (ls_grant_cnt != 16'hFFFF)) begin
                ls_grant_cnt <= ls_grant_cnt + 16'd1;
            end
        end
    end

`ifndef SYNTHESIS
    a_one_gnt: assert property (@(posedge clk) !(bus.if_gnt_o && bus.ls_gnt_o));
    a_if_hold: assert property (@(posedge clk) disable iff (reset)
        (bus.if_req_i && !bus.if_gnt_o) |=> (bus.if_req_i && $stable(bus.if_addr_i)));
    a_ls_hold: assert property (@(posedge clk) disable iff (reset)
        (bus.ls_req_i && !bus.ls_gnt_o) |=> (bus.ls_req_i && $stable(bus.ls_addr_i)));
    a_rr: assert property (@(posedge clk) disable iff (reset)
        (run && (req == 2'b11)) |-> (gnt == (last_ls ? 2'b01 : 2'b10)));
    a_if_cnt: assert property (@(posedge clk) disable iff (reset)
        (bus.if_gnt_o && (if_grant_cnt != 16'hFFFF)) |=>
        (if_grant_cnt == $past(if_grant_cnt) + 16'd1));
    a_ls_cnt: assert property (@(posedge clk) disable iff (reset)
        (bus.ls_gnt_o && (ls_grant_cnt != 16'hFFFF)) |=>
        (ls_grant_cnt == $past(ls_grant_cnt) + 16'd1));
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed sequences, an address table and random traffic
// checked cycle by cycle against a behavioural model.
module tb_rom_port_arbiter;

    localparam int unsigned RomBytes   = 8192;
    localparam int unsigned InitCycles = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rom_port_arbiter_if bus ();

    rom_port_arbiter #(
        .ROM_BYTES  (RomBytes),
        .INIT_CYCLES(InitCycles)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [31:0] rom_word(input int unsigned idx);
        return 32'h5A00_0000 + idx * 32'h0001_0203;
    endfunction

    logic [31:0] rom_q;
    always_ff @(posedge clk) begin
        if (bus.rom_en_o) rom_q <= rom_word(int'(bus.rom_addr_o[12:2]));
    end
    assign bus.rom_data_i = rom_q;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit illegal(input logic [31:0] a);
        return (a >= RomBytes) || (a % 4 != 0);
    endfunction

    // Behavioural model state.
    int          init_left;
    bit          fetch_wins;
    bit          pv_q, pport_q, perr_q;
    logic [31:0] pdata_q;
    logic [31:0] m_rom_addr;
    logic [1:0]  last_g;

    logic        s_if_gnt, s_ls_gnt, s_if_rvalid, s_ls_rvalid, s_if_err, s_ls_err, s_rom_en;
    logic [31:0] s_if_rdata, s_ls_rdata, s_rom_addr;

    task automatic model_reset();
        init_left  = InitCycles;
        fetch_wins = 1'b1;
        pv_q       = 1'b0;
        pport_q    = 1'b0;
        perr_q     = 1'b0;
        pdata_q    = '0;
        m_rom_addr = '0;
    endtask

    // One clock: sample at negedge, compare with the model, advance the model at posedge.
    task automatic tick();
        logic [1:0]  g;
        logic [31:0] ga, a_exp;
        bit          gerr, en_exp, both, pv;
        @(negedge clk);
        s_if_gnt = bus.if_gnt_o;         s_ls_gnt = bus.ls_gnt_o;
        s_if_rvalid = bus.if_rvalid_o;   s_ls_rvalid = bus.ls_rvalid_o;
        s_if_err = bus.if_err_o;         s_ls_err = bus.ls_err_o;
        s_if_rdata = bus.if_rdata_o;     s_ls_rdata = bus.ls_rdata_o;
        s_rom_en = bus.rom_en_o;         s_rom_addr = bus.rom_addr_o;
        both = bus.if_req_i && bus.ls_req_i;
        g = 2'b00;
        if (!reset && init_left == 0) begin
            if (both) g = fetch_wins ? 2'b01 : 2'b10;
            else g = {bus.ls_req_i, bus.if_req_i};
        end
        ga     = g[1] ? bus.ls_addr_i : bus.if_addr_i;
        gerr   = (g != 2'b00) && illegal(ga);
        en_exp = (g != 2'b00) && !gerr;
        a_exp  = en_exp ? ga : m_rom_addr;
        pv     = pv_q && !reset;
        chk("if_gnt", s_if_gnt, g[0]);
        chk("ls_gnt", s_ls_gnt, g[1]);
        chk("rom_en", s_rom_en, en_exp);
        chk("rom_addr", s_rom_addr, a_exp);
        chk("if_rvalid", s_if_rvalid, pv && !pport_q);
        chk("ls_rvalid", s_ls_rvalid, pv && pport_q);
        chk("if_err", s_if_err, pv && !pport_q && perr_q);
        chk("ls_err", s_ls_err, pv && pport_q && perr_q);
        chk("if_rdata", s_if_rdata, (pv && !pport_q) ? pdata_q : 32'h0);
        chk("ls_rdata", s_ls_rdata, (pv && pport_q) ? pdata_q : 32'h0);
        last_g = g;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (init_left > 0) init_left--;
            if (g != 2'b00 && both) fetch_wins = g[1];
            pv_q    = (g != 2'b00);
            pport_q = g[1];
            perr_q  = gerr;
            pdata_q = en_exp ? rom_word(ga / 4) : 32'h0;
            if (en_exp) m_rom_addr = ga;
        end
        #1;
    endtask

    // Lets each port drop its request once granted; bounded so a stuck DUT still finishes.
    task automatic drain();
        for (int i = 0; i < 10 && (bus.if_req_i || bus.ls_req_i); i++) begin
            tick();
            if (last_g[0]) bus.if_req_i = 1'b0;
            if (last_g[1]) bus.ls_req_i = 1'b0;
        end
        chk("drain_idle", {30'd0, bus.ls_req_i, bus.if_req_i}, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0: return RomBytes + ($urandom % 64) * 4;
            1: return (($urandom % 2048) * 4) | (1 + $urandom % 3);
            2: return RomBytes - 4;
            default: return ($urandom % 2048) * 4;
        endcase
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nog, n_g, n_rv, n_ls, first_rv, last_rv, sent, n_if, n_lsg, n_alt;
        logic [1:0] prev;
        vecs[0] = '{32'h0000_2000, 1'b1, 32'h0};
        vecs[1] = '{32'h0000_1FFC, 1'b0, rom_word(2047)};
        vecs[2] = '{32'h0000_0006, 1'b1, 32'h0};
        vecs[3] = '{32'h0000_0000, 1'b0, rom_word(0)};
        vecs[4] = '{32'h0000_1000, 1'b0, rom_word(1024)};
        vecs[5] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
        vecs[6] = '{32'h0000_1FFE, 1'b1, 32'h0};
        vecs[7] = '{32'h0000_0044, 1'b0, rom_word(17)};

        reset = 1'b1;
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h0;
        bus.ls_req_i = 1'b0; bus.ls_addr_i = 32'h0;
        model_reset();
        last_g = 2'b00;
        @(posedge clk); #1;

        // Reset state, then fetch held from cycle 0 through the hold-off window.
        tick();
        chk("reset_rom_addr", s_rom_addr, 32'h0);
        chk("reset_if_rdata", s_if_rdata, 32'h0);
        chk("reset_ls_rdata", s_ls_rdata, 32'h0);
        tick();
        reset = 1'b0;
        nog = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_if_gnt) break;
            nog++;
        end
        chk("init_hold_cycles", nog, InitCycles);
        for (int k = 0; k < 3; k++) begin
            if (k < 2) bus.if_addr_i = 32'(4 * (k + 1));
            else bus.if_req_i = 1'b0;
            tick();
            chk("seq_fetch_rvalid", s_if_rvalid, 1'b1);
            chk("seq_fetch_rdata", s_if_rdata, rom_word(k));
        end

        // Both ports requesting every cycle.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h10;
        bus.ls_req_i = 1'b1; bus.ls_addr_i = 32'h20;
        n_if = 0; n_lsg = 0; n_alt = 0; prev = 2'b00;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (s_if_gnt) n_if++;
            if (s_ls_gnt) n_lsg++;
            if (i > 0 && {s_ls_gnt, s_if_gnt} == prev) n_alt++;
            prev = {s_ls_gnt, s_if_gnt};
        end
        chk("conflict_if_count", n_if, 50);
        chk("conflict_ls_count", n_lsg, 50);
        chk("conflict_repeats", n_alt, 0);
        drain();

        // Address screening table on the load port.
        foreach (vecs[i]) begin
            bus.ls_req_i = 1'b1; bus.ls_addr_i = vecs[i].addr;
            tick();
            chk("tbl_gnt", s_ls_gnt, 1'b1);
            chk("tbl_rom_en", s_rom_en, !vecs[i].err);
            bus.ls_req_i = 1'b0;
            tick();
            chk("tbl_rvalid", s_ls_rvalid, 1'b1);
            chk("tbl_err", s_ls_err, vecs[i].err);
            chk("tbl_rdata", s_ls_rdata, vecs[i].data);
        end

        // Fetch streaming with load idle.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
        n_g = 0; n_rv = 0; n_ls = 0; first_rv = -1; last_rv = -1; sent = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (s_if_gnt) n_g++;
            if (s_ls_rvalid) n_ls++;
            if (s_if_rvalid) begin
                n_rv++;
                if (first_rv < 0) first_rv = i;
                last_rv = i;
            end
            if (s_if_gnt) begin
                sent++;
                if (sent == 50) bus.if_req_i = 1'b0;
                else bus.if_addr_i += 4;
            end
        end
        chk("stream_grants", n_g, 50);
        chk("stream_rvalids", n_rv, 50);
        chk("stream_span", last_rv - first_rv + 1, 50);
        chk("stream_ls_rvalid", n_ls, 0);

        // Load granted while the previous fetch response is delivered.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h80;
        tick();
        chk("xover_if_gnt", s_if_gnt, 1'b1);
        bus.if_req_i = 1'b0;
        bus.ls_req_i = 1'b1; bus.ls_addr_i = 32'h84;
        tick();
        chk("xover_ls_gnt", s_ls_gnt, 1'b1);
        chk("xover_if_rvalid", s_if_rvalid, 1'b1);
        chk("xover_if_rdata", s_if_rdata, rom_word(32));
        chk("xover_ls_rvalid_early", s_ls_rvalid, 1'b0);
        bus.ls_req_i = 1'b0;
        tick();
        chk("xover_ls_rvalid", s_ls_rvalid, 1'b1);
        chk("xover_ls_rdata", s_ls_rdata, rom_word(33));
        chk("xover_if_quiet", s_if_rvalid, 1'b0);
        chk("xover_if_rdata0", s_if_rdata, 32'h0);

        // Reset asserted the cycle after a grant.
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h40;
        tick();
        chk("rst_first_gnt", s_if_gnt, 1'b1);
        bus.if_addr_i = 32'h44;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nog = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) chk("rst_dropped_rvalid", s_if_rvalid, 1'b0);
            if (s_if_gnt) break;
            nog++;
        end
        chk("rst_regrant_delay", nog, InitCycles);
        drain();

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            tick();
            if (!bus.if_req_i || last_g[0]) begin
                bus.if_req_i = ($urandom % 4) != 0;
                bus.if_addr_i = rand_addr();
            end
            if (!bus.ls_req_i || last_g[1]) begin
                bus.ls_req_i = ($urandom % 3) != 0;
                bus.ls_addr_i = rand_addr();
            end
            reset = ($urandom % 80) == 0;
        end
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Arbiter and sequencer for the single-port instruction ROM: it shares the ROM read port between the instruction-fetch unit and the load unit, which reads constant tables. It holds off all traffic for a fixed post-reset window while the ROM image loads. It screens out-of-range and misaligned addresses and returns each read response to the requester that issued it. It sits between the core's fetch and load-store front ends and the ROM's `en`/`address_i`/`data_o` port.

## Interface
Parameters:
- `ROM_BYTES`, default 8192: ROM size in bytes, i.e. 2048 words of 32 bits.
- `INIT_CYCLES`, default 4: number of cycles after reset release during which no grant is issued.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `if_req_i`  in  1  fetch request.
- `if_addr_i`  in  `API_ADDR_WIDTH`  fetch byte address.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch response valid.
- `if_rdata_o`  out  `API_DATA_WIDTH`  fetch response data.
- `if_err_o`  out  1  fetch response is an error; qualified by `if_rvalid_o`.
- `ls_req_i`, `ls_addr_i`, `ls_gnt_o`, `ls_rvalid_o`, `ls_rdata_o`, `ls_err_o`: same signals as the fetch port, for the load unit.
- `rom_en_o`  out  1  ROM read enable.
- `rom_addr_o`  out  `API_ADDR_WIDTH`  ROM byte address.
- `rom_data_i`  in  `API_DATA_WIDTH`  ROM read data, registered inside the ROM, one cycle after `en`.

## Operation
- States:
  - `INIT`: entered on `reset`. A counter runs from 0 to `INIT_CYCLES`-1. No grants are issued in this state. Moves to `RUN` after the last count.
  - `RUN`: normal arbitration.
- Handshake:
  - A requester holds `req` and `addr` stable until it sees `gnt`.
  - `gnt` is combinational from `req` and the current state.
  - At most one grant per cycle across both ports.
  - Responses cannot be back-pressured.
- Arbitration:
  - If only one port requests, that port is granted.
  - If both request, the grant goes to the port not granted last time (round-robin pointer `last_ls`). At reset the pointer favours fetch.
  - The pointer updates only on a cycle with a conflict.
- Address check on the granted request:
  - `addr >= ROM_BYTES` or `addr[1:0] != 0` is an error.
  - On an error, `rom_en_o` stays 0 and the ROM is not accessed.
  - The request is still granted and completes with an error response.
- ROM drive:
  - On a legal grant, `rom_en_o`=1 and `rom_addr_o` = the granted address.
  - Otherwise `rom_en_o`=0 and `rom_addr_o` holds its last value.
- Response tag register, written every cycle: `{valid, port, err}`.
  - In cycle N+1 the tagged port asserts `rvalid` for exactly one cycle.
  - `rdata` = `rom_data_i` on success, 0 on error. The other port's `rdata` is 0.
- Counters: saturating 16-bit `if_grant_cnt` and `ls_grant_cnt`, exposed only for debug/assertions; they are not ports.

## Timing
- Reset values:
  - All `gnt`, `rvalid` and `err` outputs = 0.
  - `rdata` outputs = 0, `rom_en_o`=0, `rom_addr_o`=0.
  - State = `INIT`, counter = 0, `last_ls`=1 (so fetch wins the first conflict).
- Latency:
  - Grant at cycle N gives a response at N+1.
  - Back-to-back grants give one response per cycle, with full throughput.
- First grant can occur in the cycle that follows exactly `INIT_CYCLES` cycles of `INIT` after `reset` deasserts.
- `reset` asserted mid-operation: a pending response is dropped and `rvalid` is 0 in the next cycle.
- Simultaneous request and response on the same port is legal; the new grant's response follows one cycle later.
- Request deasserted without a grant: no effect on the arbiter (it is a requester protocol violation, flagged by assertion).
- Address wrap: `ROM_BYTES`-4 is legal; `ROM_BYTES` is an error. There is no modulo wrap.

## Structure
- Shared package/defines holds `API_ADDR_WIDTH`, `API_DATA_WIDTH` (both 32), the state encoding `ST_INIT`/`ST_RUN`, and the port ID constants `PORT_IF`=0 and `PORT_LS`=1.
- One sub-module, `rr_arb2`: 2-way round-robin with `req[1:0]`, `gnt[1:0]` and the `last` pointer. Range check, FSM and response tagging stay in the top module.

## Test plan
- Reset, then fetch requests continuously from cycle 0 -> no `gnt` for `INIT_CYCLES`=4 cycles, then grants at addresses 0x0, 0x4, 0x8 with responses one cycle later equal to the ROM words 0, 1, 2.
- Both ports request every cycle, fetch at 0x10 and load at 0x20 -> grants alternate IF, LS, IF, LS; each `rvalid` appears on the correct port; counts are equal after 100 cycles.
- Load at 0x2000, then 0x1FFC, then 0x6 -> 0x2000: `ls_err_o`=1 with `rdata` 0 and `rom_en_o` never high. 0x1FFC: word 2047 returned. 0x6: error.
- Single-port streaming with load idle, 50 fetches -> 50 consecutive `if_rvalid_o` pulses with no bubbles; `ls_rvalid_o` stays 0.
- `reset` asserted the cycle after a grant -> no `rvalid` the following cycle; FSM back in `INIT`; the fetch is re-granted only after 4 cycles.
- Request on load while the fetch response for the previous cycle is being delivered -> load granted at N; fetch `rvalid` at N and load `rvalid` at N+1, with no data cross-over.
